// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Command-side initiator for an 8-bit combinational ALU. Requests are
//   buffered in a DEPTH-entry FIFO. Each request is then driven to the ALU
//   from registers. The ALU result is captured one cycle later and returned
//   in order through a valid/ready response port.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready  request handshake; cmd_op/cmd_a/cmd_b/cmd_tag payload
//   alu_a/alu_b/alu_sel  registered ALU operands and select
//   alu_out              combinational ALU result
//   rsp_valid/rsp_ready  response handshake; rsp_data/rsp_tag/rsp_dz payload
//   pending              FIFO occupancy
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   cmd_op,
    input  logic [7:0]                   cmd_a,
    input  logic [7:0]                   cmd_b,
    input  logic [TAG_W-1:0]             cmd_tag,
    output logic [7:0]                   alu_a,
    output logic [7:0]                   alu_b,
    output logic [3:0]                   alu_sel,
    input  logic [7:0]                   alu_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [7:0]                   rsp_data,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic                         rsp_dz,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    typedef struct packed {
        logic             dz;
        logic [TAG_W-1:0] tag;
        logic [3:0]       op;
        logic [7:0]       a;
        logic [7:0]       b;
    } entry_t;

    state_t           state;
    entry_t           mem [DEPTH];
    entry_t           head;
    entry_t           new_entry;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [PW-1:0]    pend_next;
    logic [TAG_W-1:0] cur_tag;
    logic             cur_dz;
    logic             push;
    logic             pop;

    assign cmd_ready = (pending < PW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // A pop happens in IDLE with work queued, or on the response handshake
    // if more work is waiting. This must match the FSM branches below.
    assign pop       = (pending != '0) &&
                       ((state == IDLE) || ((state == RESP) && rsp_valid && rsp_ready));
    assign head      = mem[rd_ptr];

    // Divide-by-zero is decided at push time so the ALU result can be ignored.
    always_comb begin
        new_entry     = '0;
        new_entry.dz  = (cmd_op == 4'b0011) && (cmd_b == 8'd0);
        new_entry.tag = cmd_tag;
        new_entry.op  = cmd_op;
        new_entry.a   = cmd_a;
        new_entry.b   = cmd_b;
    end

    always_comb begin
        pend_next = pending;
        if (push && !pop) begin
            pend_next = pending + PW'(1);
        end else if (!push && pop) begin
            pend_next = pending - PW'(1);
        end
    end

    // The storage array has no reset. Stale contents are never read, because
    // a read only happens when pending is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pending   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            cur_tag   <= '0;
            cur_dz    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_dz    <= 1'b0;
        end else begin
            pending <= pend_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_sel <= head.op;
                cur_tag <= head.tag;
                cur_dz  <= head.dz;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    rsp_data  <= cur_dz ? 8'hFF : alu_out;
                    rsp_tag   <= cur_tag;
                    rsp_dz    <= cur_dz;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? DRIVE : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [1:0] cmd_tag;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_tag;
    logic       rsp_dz;
    logic [2:0] pending;

    typedef struct {
        logic [7:0] d;
        logic [1:0] tag;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   rsp_times[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    alu_cmd_issuer #(.DEPTH(4), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_dz(rsp_dz),
        .pending(pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU attached to the DUT's operand outputs
    always_comb begin
        case (alu_sel)
            4'h0: alu_out = alu_a + alu_b;
            4'h1: alu_out = alu_a - alu_b;
            4'h2: alu_out = 8'(alu_a * alu_b);
            4'h3: alu_out = (alu_b == 8'd0) ? 8'h00 : alu_a / alu_b;
            4'h4: alu_out = (alu_b == 8'd0) ? 8'h00 : alu_a % alu_b;
            4'h5: alu_out = alu_a << alu_b[2:0];
            4'h6: alu_out = {alu_a[6:0], alu_a[7]};
            4'h7: alu_out = {alu_a[0], alu_a[7:1]};
            4'h8: alu_out = alu_a & alu_b;
            4'h9: alu_out = alu_a | alu_b;
            4'hA: alu_out = alu_a ^ alu_b;
            4'hB: alu_out = ~alu_a;
            4'hC: alu_out = alu_a >> alu_b[2:0];
            4'hD: alu_out = {7'd0, alu_a < alu_b};
            4'hE: alu_out = {7'd0, alu_a > alu_b};
            default: alu_out = {7'd0, alu_a == alu_b};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] tag, input logic [7:0] exp_d, input logic exp_dz);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            check("send_ready_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back('{d: exp_d, tag: tag, dz: exp_dz});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !rsp_valid && pending == 3'd0) && n < 80) begin
            tick();
            n++;
        end
        check(name, {29'd0, (sb.size() == 0), rsp_valid, (pending == 3'd0)}, 32'b101);
    endtask

    // Monitor: a handshake seen here completes at the next rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", {24'd0, rsp_data}, {24'd0, e.d});
                    check("rsp_tag", {30'd0, rsp_tag}, {30'd0, e.tag});
                    check("rsp_dz", {31'd0, rsp_dz}, {31'd0, e.dz});
                end
                rsp_times.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_tag = '0;
        rsp_ready = 1'b0;
        #12;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_pending", {29'd0, pending}, 32'd0);
        check("reset_alu", {12'd0, alu_a, alu_b, alu_sel}, 32'd0);
        check("reset_rsp", {21'd0, rsp_data, rsp_tag, rsp_dz}, 32'd0);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: 200+100 -> 44
        rsp_ready = 1'b1;
        send(4'b0000, 8'd200, 8'd100, 2'd1, 8'd44, 1'b0);
        check("lat_e0_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("lat_e1_valid", {31'd0, rsp_valid}, 32'd0);
        check("lat_e1_alu", {12'd0, alu_a, alu_b, alu_sel}, {12'd0, 8'd200, 8'd100, 4'd0});
        tick();
        check("lat_e2_valid", {31'd0, rsp_valid}, 32'd1);
        check("lat_e2_data", {22'd0, rsp_data, rsp_tag}, {22'd0, 8'd44, 2'd1});
        tick();
        check("lat_e3_valid", {31'd0, rsp_valid}, 32'd0);
        check("lat_e3_pending", {29'd0, pending}, 32'd0);

        // Divide by zero, then a normal divide
        send(4'b0011, 8'd9, 8'd0, 2'd2, 8'hFF, 1'b1);
        send(4'b0011, 8'd9, 8'd2, 2'd3, 8'd4, 1'b0);
        drain("drain_div");

        // Full backpressure: DEPTH+1 accepts
        rsp_ready = 1'b0;
        k = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cmd_op  = 4'b0000;
            cmd_a   = 8'(k);
            cmd_b   = 8'd10;
            cmd_tag = 2'(k);
            if (cmd_ready) begin
                sb.push_back('{d: 8'(k + 10), tag: 2'(k), dz: 1'b0});
                k++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_accepts", k, 32'd5);
        check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("bp_pending", {29'd0, pending}, 32'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {21'd0, rsp_valid, rsp_tag, rsp_data}, {21'd0, 1'b1, 2'd0, 8'd10});
            tick();
        end
        rsp_ready = 1'b1;
        drain("drain_bp");

        // Ordering and throughput
        n0 = rsp_times.size();
        send(4'b0110, 8'h81, 8'h00, 2'd0, 8'h03, 1'b0);
        send(4'b1111, 8'h5A, 8'h5A, 2'd1, 8'h01, 1'b0);
        send(4'b0001, 8'd3, 8'd5, 2'd2, 8'hFE, 1'b0);
        drain("drain_order");
        check("order_count", rsp_times.size() - n0, 32'd3);
        if (rsp_times.size() - n0 == 3) begin
            check("order_gap1", rsp_times[n0 + 1] - rsp_times[n0], 32'd2);
            check("order_gap2", rsp_times[n0 + 2] - rsp_times[n0 + 1], 32'd2);
        end

        // Asynchronous reset while in RESP with two queued
        rsp_ready = 1'b0;
        send(4'b0000, 8'd1, 8'd1, 2'd0, 8'd2, 1'b0);
        send(4'b0000, 8'd2, 8'd1, 2'd1, 8'd3, 1'b0);
        send(4'b0000, 8'd3, 8'd1, 2'd2, 8'd4, 1'b0);
        check("arst_pre_pending", {29'd0, pending}, 32'd2);
        check("arst_pre_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_pending", {29'd0, pending}, 32'd0);
        check("arst_alu_sel", {28'd0, alu_sel}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        send(4'b1000, 8'hF0, 8'h3C, 2'd3, 8'h30, 1'b0);
        drain("drain_arst");

        // Push coinciding with handshake and pop
        rsp_ready = 1'b0;
        send(4'b1001, 8'h10, 8'h01, 2'd0, 8'h11, 1'b0);
        send(4'b1010, 8'hFF, 8'h0F, 2'd1, 8'hF0, 1'b0);
        send(4'b1011, 8'h55, 8'h00, 2'd2, 8'hAA, 1'b0);
        check("same_pre_pending", {29'd0, pending}, 32'd2);
        n0 = rsp_times.size();
        rsp_ready = 1'b1;
        send(4'b0010, 8'd7, 8'd6, 2'd3, 8'd42, 1'b0);
        check("same_pending", {29'd0, pending}, 32'd2);
        drain("drain_same");
        check("same_count", rsp_times.size() - n0, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
